// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and EX/MEM, MEM/WB operand forwarding.
// Held fields only move on an accepted handshake; forwarding is re-evaluated every cycle.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_alu_op,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [3:0]      alu_op,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_data,
  output logic [15:0]     bubble_count
);

  logic            valid_r;
  logic [RA_W-1:0] rs1_r, rs2_r, rd_r;
  logic            rs1_used_r, rs2_used_r, use_imm_r, reg_write_r, is_load_r;
  logic [XLEN-1:0] rs1_data_r, rs2_data_r, imm_r;
  logic [3:0]      alu_op_r;
  logic [15:0]     bubble_cnt_r;
  logic            hazard_s;
  logic            ready_s;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s;

  // MEM beats WB; x0 and unread sources always take the register-file value
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            used,
    input logic [XLEN-1:0] held_data,
    input logic [RA_W-1:0] m_rd,
    input logic            m_we,
    input logic [XLEN-1:0] m_val,
    input logic [RA_W-1:0] w_rd,
    input logic            w_we,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] r;
    if (!used || src == {RA_W{1'b0}}) begin
      r = held_data;
    end else if (m_we && m_rd == src) begin
      r = m_val;
    end else if (w_we && w_rd == src) begin
      r = w_val;
    end else begin
      r = held_data;
    end
    return r;
  endfunction

  // Load-use hazard detection and the decode handshake
  always_comb begin
    hazard_s = valid_r && is_load_r && reg_write_r && (rd_r != {RA_W{1'b0}}) &&
               ((id_rs1_used && id_rs1 == rd_r) || (id_rs2_used && id_rs2 == rd_r));
    ready_s  = !flush && !hazard_s && (!valid_r || ex_ready);
  end

  // Operand forwarding against the live MEM/WB producers
  always_comb begin
    fwd_a_s = fwd_sel(rs1_r, rs1_used_r, rs1_data_r, mem_rd, mem_reg_write, mem_result,
                      wb_rd, wb_reg_write, wb_data);
    fwd_b_s = fwd_sel(rs2_r, rs2_used_r, rs2_data_r, mem_rd, mem_reg_write, mem_result,
                      wb_rd, wb_reg_write, wb_data);
    if (use_imm_r) begin
      operand_b = imm_r;
    end else begin
      operand_b = fwd_b_s;
    end
    operand_a = fwd_a_s;
  end

  // Pipeline register: flush, then capture, then drain, else hold
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      rs1_r       <= {RA_W{1'b0}};
      rs2_r       <= {RA_W{1'b0}};
      rd_r        <= {RA_W{1'b0}};
      rs1_used_r  <= 1'b0;
      rs2_used_r  <= 1'b0;
      use_imm_r   <= 1'b0;
      reg_write_r <= 1'b0;
      is_load_r   <= 1'b0;
      rs1_data_r  <= {XLEN{1'b0}};
      rs2_data_r  <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      alu_op_r    <= 4'd0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (id_valid && ready_s) begin
      valid_r     <= 1'b1;
      rs1_r       <= id_rs1;
      rs2_r       <= id_rs2;
      rd_r        <= id_rd;
      rs1_used_r  <= id_rs1_used;
      rs2_used_r  <= id_rs2_used;
      use_imm_r   <= id_use_imm;
      reg_write_r <= id_reg_write;
      is_load_r   <= id_is_load;
      rs1_data_r  <= id_rs1_data;
      rs2_data_r  <= id_rs2_data;
      imm_r       <= id_imm;
      alu_op_r    <= id_alu_op;
    end else if (ex_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Saturating load-use bubble counter; survives flush
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= 16'd0;
    end else if (hazard_s && id_valid && (!valid_r || ex_ready) && !flush &&
                 bubble_cnt_r != 16'hFFFF) begin
      bubble_cnt_r <= bubble_cnt_r + 16'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign id_ready     = ready_s;
  assign ex_valid     = valid_r;
  assign alu_op       = alu_op_r;
  assign ex_rd        = rd_r;
  assign ex_reg_write = reg_write_r && valid_r;
  assign ex_is_load   = is_load_r && valid_r;
  assign bubble_count = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the held instruction.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd, ex_rd, mem_rd, wb_rd;
  logic        id_rs1_used, id_rs2_used, id_use_imm, id_reg_write, id_is_load;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]  id_alu_op, alu_op;
  logic        ex_valid, ex_ready, ex_reg_write, ex_is_load;
  logic [31:0] operand_a, operand_b, mem_result, wb_data;
  logic        mem_reg_write, wb_reg_write;
  logic [15:0] bubble_count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_result(mem_result), .wb_data(wb_data),
    .bubble_count(bubble_count)
  );

  // Model: the instruction currently held, as a record
  typedef struct {
    bit          valid;
    bit [4:0]    rs1, rs2, rd;
    bit          rs1_used, rs2_used, use_imm, reg_write, is_load;
    bit [31:0]   rs1_data, rs2_data, imm;
    bit [3:0]    op;
  } instr_t;

  instr_t held;
  int     bubbles;

  function automatic bit model_hazard();
    return held.valid && held.is_load && held.reg_write && held.rd != 5'd0 &&
           ((id_rs1_used && id_rs1 == held.rd) || (id_rs2_used && id_rs2 == held.rd));
  endfunction

  function automatic bit model_ready();
    return !flush && !model_hazard() && (!held.valid || ex_ready);
  endfunction

  function automatic bit [31:0] model_operand(bit [4:0] src, bit used, bit [31:0] regval);
    if (used && src != 5'd0) begin
      if (mem_reg_write && mem_rd == src) return mem_result;
      if (wb_reg_write && wb_rd == src) return wb_data;
    end
    return regval;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state update at each clock edge
  always @(posedge clk) begin
    if (rst) begin
      held    = '{default: 0};
      bubbles = 0;
    end else begin
      if (model_hazard() && id_valid && (!held.valid || ex_ready) && !flush && bubbles < 65535)
        bubbles++;
      if (flush) held.valid = 1'b0;
      else if (id_valid && model_ready()) begin
        held.valid = 1'b1;
        held.rs1 = id_rs1; held.rs2 = id_rs2; held.rd = id_rd;
        held.rs1_used = id_rs1_used; held.rs2_used = id_rs2_used;
        held.use_imm = id_use_imm; held.reg_write = id_reg_write; held.is_load = id_is_load;
        held.rs1_data = id_rs1_data; held.rs2_data = id_rs2_data; held.imm = id_imm;
        held.op = id_alu_op;
      end else if (ex_ready) held.valid = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("id_ready", {31'd0, id_ready}, {31'd0, model_ready()});
      check("ex_valid", {31'd0, ex_valid}, {31'd0, held.valid});
      check("operand_a", operand_a, model_operand(held.rs1, held.rs1_used, held.rs1_data));
      check("operand_b", operand_b, held.use_imm ? held.imm :
                                     model_operand(held.rs2, held.rs2_used, held.rs2_data));
      check("alu_op", {28'd0, alu_op}, {28'd0, held.op});
      check("ex_rd", {27'd0, ex_rd}, {27'd0, held.rd});
      check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, held.reg_write & held.valid});
      check("ex_is_load", {31'd0, ex_is_load}, {31'd0, held.is_load & held.valid});
      check("bubble_count", {16'd0, bubble_count}, bubbles);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0; id_alu_op = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; ex_ready = 1;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0; mem_result = 0; wb_data = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset bubble", {16'd0, bubble_count}, 32'd0);

    // 1: simple ADD
    tick();
    id_valid = 1; id_alu_op = 4'd0; id_rs1 = 1; id_rs2 = 2; id_rs1_used = 1; id_rs2_used = 1;
    id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_rd = 5; id_reg_write = 1;
    tick();
    id_valid = 0;
    @(negedge clk);
    check("t1 ex_valid", {31'd0, ex_valid}, 32'd1);
    check("t1 operand_a", operand_a, 32'd5);
    check("t1 operand_b", operand_b, 32'd7);
    check("t1 id_ready", {31'd0, id_ready}, 32'd1);

    // 2: MEM over WB, then WB, then x0
    tick();
    id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h1111; id_rd = 0;
    tick();
    id_valid = 0; ex_ready = 0;
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'hAAAA;
    wb_rd = 3; wb_reg_write = 1; wb_data = 32'h5555;
    @(negedge clk);
    check("t2 mem fwd", operand_a, 32'hAAAA);
    mem_reg_write = 0;
    #1;
    check("t2 wb fwd", operand_a, 32'h5555);
    tick();
    ex_ready = 1; id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h2222;
    mem_rd = 0; mem_reg_write = 1; wb_rd = 0;
    tick();
    id_valid = 0;
    @(negedge clk);
    check("t2 x0 no fwd", operand_a, 32'h2222);

    // 3: load-use bubble
    tick();
    clear_inputs();
    id_valid = 1; id_is_load = 1; id_reg_write = 1; id_rd = 4;
    tick();
    id_is_load = 0; id_rd = 6; id_rs2 = 4; id_rs2_used = 1; id_rs2_data = 32'h44;
    id_rs1 = 7; id_rs1_used = 1; id_rs1_data = 32'h77;
    @(negedge clk);
    check("t3 stall ready", {31'd0, id_ready}, 32'd0);
    tick();
    @(negedge clk);
    check("t3 bubble ex_valid", {31'd0, ex_valid}, 32'd0);
    check("t3 bubble count", {16'd0, bubble_count}, 32'd1);
    check("t3 ready after", {31'd0, id_ready}, 32'd1);
    tick();
    @(negedge clk);
    check("t3 accepted", {31'd0, ex_valid}, 32'd1);
    check("t3 ex_rd", {27'd0, ex_rd}, 32'd6);

    // 4: execute stall with a WB producer changing mid-stall
    tick();
    ex_ready = 0; id_rd = 9; id_rs1_data = 32'h99;
    wb_rd = 7; wb_reg_write = 1; wb_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) wb_data = 32'hBEEF;
      @(negedge clk);
      check("t4 stall ready", {31'd0, id_ready}, 32'd0);
      check("t4 held rd", {27'd0, ex_rd}, 32'd6);
      check("t4 fwd a", operand_a, (i == 0) ? 32'h1234 : 32'hBEEF);
      tick();
    end
    id_valid = 0; ex_ready = 1;
    tick();

    // 5: flush kills the offer
    flush = 1; id_valid = 1; id_rd = 10;
    @(negedge clk);
    check("t5 ready", {31'd0, id_ready}, 32'd0);
    tick();
    flush = 0; id_valid = 0;
    @(negedge clk);
    check("t5 ex_valid", {31'd0, ex_valid}, 32'd0);
    check("t5 nothing captured", {27'd0, ex_rd}, 32'd6);

    // 6: immediate wins over forwarding, then reset during a stall
    tick();
    clear_inputs();
    id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFFFFF0; id_rs2 = 8; id_rs2_used = 1;
    id_rs2_data = 32'h88; id_alu_op = 4'd3; id_rd = 2;
    mem_rd = 8; mem_reg_write = 1; mem_result = 32'hAAAA;
    tick();
    ex_ready = 0;
    @(negedge clk);
    check("t6 imm", operand_b, 32'hFFFFFFF0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("t6 rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("t6 rst op_a", operand_a, 32'd0);
    check("t6 rst op_b", operand_b, 32'd0);
    check("t6 rst alu_op", {28'd0, alu_op}, 32'd0);
    check("t6 rst ex_rd", {27'd0, ex_rd}, 32'd0);

    // Randomized traffic with small register indices for frequent collisions
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      id_valid = $urandom_range(0, 3) != 0;
      ex_ready = $urandom_range(0, 3) != 0;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_use_imm = 1'($urandom); id_reg_write = 1'($urandom); id_is_load = 1'($urandom);
      id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_alu_op = 4'($urandom);
      mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7));
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      mem_result = $urandom; wb_data = $urandom;
    end
    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
